// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_funct3_t f);
    return f[2];
  endfunction

  function automatic logic is_signed_a(input muldiv_funct3_t f);
    return f inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_funct3_t f);
    return f inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step (mode=0) or restoring divide step (mode=1).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] acc,
  input  logic            in_bit,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic            q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;

  always_comb begin
    sum     = {1'b0, acc} + (in_bit ? {1'b0, operand} : '0);
    shifted = {acc, in_bit};
    if (mode) begin
      // Partial remainder stays below the divisor, so the low XLEN bits of the difference suffice.
      q_bit    = (shifted >= {1'b0, operand});
      acc_next = q_bit ? (shifted[XLEN-1:0] - operand) : shifted[XLEN-1:0];
    end else begin
      q_bit    = sum[0];
      acc_next = sum[XLEN:1];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and kill.
// Optional early-out for trivial operands: define MULDIV_FAST_PATH_EN.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN) + 1;

  muldiv_state_t   state, state_next;
  muldiv_funct3_t  f_in, op;
  logic            accept;
  logic            neg_a, neg_b, div_zero;
  logic            in_neg_a, in_neg_b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] acc, lo, opb;
  logic [CNT_W-1:0] cnt;
  logic            step_in_bit, step_q;
  logic [XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, fix_result;
  logic            fast_hit, fast_q;
  logic [XLEN-1:0] fast_val, fast_res;

  assign f_in     = muldiv_funct3_t'(funct3);
  assign in_neg_a = is_signed_a(f_in) && rs1[XLEN-1];
  assign in_neg_b = is_signed_b(f_in) && rs2[XLEN-1];
  assign a_abs    = in_neg_a ? (~rs1 + 1'b1) : rs1;
  assign b_abs    = in_neg_b ? (~rs2 + 1'b1) : rs2;

`ifdef MULDIV_FAST_PATH_EN
  always_comb begin
    fast_hit = 1'b0;
    fast_val = '0;
    if (is_div(f_in)) begin
      if (rs2 == '0) begin
        fast_hit = 1'b1;
        fast_val = f_in[1] ? rs1 : '1;
      end else if (is_signed_b(f_in) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)) begin
        fast_hit = 1'b1;
        fast_val = f_in[1] ? '0 : rs1;
      end
    end else if ((rs1 == '0) || (rs2 == '0)) begin
      fast_hit = 1'b1;
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_val = '0;
`endif

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !kill) begin
          accept     = 1'b1;
          state_next = fast_hit ? FIX : CALC;
        end
      end
      CALC: begin
        if (kill)                     state_next = IDLE;
        else if (cnt == CNT_W'(1))    state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: begin
        out_valid = 1'b1;
        if (kill || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign step_in_bit = is_div(op) ? lo[XLEN-1] : lo[0];

  muldiv_step #(.XLEN(XLEN)) u_step (
    .mode     (is_div(op)),
    .acc      (acc),
    .in_bit   (step_in_bit),
    .operand  (opb),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Quotient is not negated on divide-by-zero so the all-ones result survives a negative dividend.
  always_comb begin
    prod   = {acc, lo};
    prod_s = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
    quot_s = ((neg_a ^ neg_b) && !div_zero) ? (~lo + 1'b1) : lo;
    rem_s  = neg_a ? (~acc + 1'b1) : acc;
    case (op)
      F3_MUL:                      fix_result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fix_result = quot_s;
      default:                     fix_result = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= F3_MUL;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opb      <= '0;
      cnt      <= '0;
      fast_q   <= 1'b0;
      fast_res <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op       <= f_in;
          neg_a    <= in_neg_a;
          neg_b    <= in_neg_b;
          div_zero <= (rs2 == '0);
          acc      <= '0;
          lo       <= a_abs;
          opb      <= b_abs;
          cnt      <= CNT_W'(XLEN);
          fast_q   <= fast_hit;
          fast_res <= fast_val;
        end
        CALC: if (!kill) begin
          acc <= step_acc;
          lo  <= is_div(op) ? {lo[XLEN-2:0], step_q} : {step_q, lo[XLEN-1:1]};
          cnt <= cnt - CNT_W'(1);
        end
        FIX: if (!kill) result <= fast_q ? fast_res : fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32) against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit host arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MULDIV_FAST_PATH_EN
    if (f[2] && b == 0) lat = 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 2;
    if (!f[2] && (a == 0 || b == 0)) lat = 2;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit end_by_kill);
    logic [31:0] exp;
    int n;
    exp = model(f, a, b);
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_latency(f, a, b)));
    check("result", result, exp);
    check("busy_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, exp);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    if (end_by_kill) kill = 1'b1;
    else             out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_result", result, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) check("exclusive_handshake", {31'b0, out_valid & in_ready}, 32'd0);
  end

  initial begin
    logic [31:0] prev;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    funct3 = 3'd0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    do_op(3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    do_op(3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd5, 32'h0000_0005, 32'h0000_0000, 0, 1'b0);
    do_op(3'd7, 32'h0000_0005, 32'h0000_0000, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 0, 1'b0);

    // kill on cycle 10 of a divide
    prev = result;
    in_valid = 1'b1; funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_in_ready", {31'b0, in_ready}, 32'd1);
    check("kill_out_valid", {31'b0, out_valid}, 32'd0);
    check("kill_result", result, prev);
    repeat (3) @(posedge clk);
    #1;
    check("kill_no_late_valid", {31'b0, out_valid}, 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 0, 1'b0);

    // kill wins over in_valid while idle
    in_valid = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("idle_kill_no_accept", {31'b0, in_ready}, 32'd1);

    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0);
    do_op(3'd1, 32'hDEAD_BEEF, 32'h0000_1000, 2, 1'b1);

    // reset during CALC
    in_valid = 1'b1; funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2),
            $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
